// File: rtl/vec_mem_sequencer_if.sv
// Bus bundle between the M stage, the data-memory port and the vector memory sequencer.
// The sequencer takes the slave view; the pipeline/memory side takes the master view.
interface vec_mem_sequencer_if #(
    parameter int LANES  = 8,
    parameter int LANE_W = 32,
    parameter int ADDR_W = 32
);
    logic                    vstart;
    logic                    vwe;
    logic [ADDR_W-1:0]       vaddr;
    logic [LANES*LANE_W-1:0] vwdata;
    logic [ADDR_W-1:0]       s_addr;
    logic                    s_we;
    logic [LANE_W-1:0]       s_wdata;
    logic [LANE_W-1:0]       mem_rdata;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_we;
    logic [LANE_W-1:0]       mem_wdata;
    logic                    stall;
    logic                    busy;
    logic                    done;
    logic [LANES*LANE_W-1:0] vrdata;

    modport slave (
        input  vstart, vwe, vaddr, vwdata, s_addr, s_we, s_wdata, mem_rdata,
        output mem_addr, mem_we, mem_wdata, stall, busy, done, vrdata
    );

    modport master (
        output vstart, vwe, vaddr, vwdata, s_addr, s_we, s_wdata, mem_rdata,
        input  mem_addr, mem_we, mem_wdata, stall, busy, done, vrdata
    );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Serialises 8-lane vector loads/stores onto the single 32-bit data-memory port,
// sharing it with scalar accesses and stalling the pipeline until the vector op finishes.
module vec_mem_sequencer #(
    parameter int LANES  = 8,
    parameter int LANE_W = 32,
    parameter int ADDR_W = 32
) (
    input logic               clk,
    input logic               reset,
    vec_mem_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [ADDR_W-1:0]       base;
    logic [LANES*LANE_W-1:0] wdataLat;
    logic                    weLat;
    logic [LANES*LANE_W-1:0] vrdataReg;
    logic                    doneReg;
    logic                    busyReg;
    logic [IDX_W-1:0]        capIdx;

    // Sync-read memory: data for the lane issued last cycle arrives now.
    assign capIdx = idx - IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            base      <= '0;
            wdataLat  <= '0;
            weLat     <= 1'b0;
            vrdataReg <= '0;
            doneReg   <= 1'b0;
            busyReg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.vstart) begin
                        base     <= bus.vaddr & ~ADDR_W'(3);
                        wdataLat <= bus.vwdata;
                        weLat    <= bus.vwe;
                        idx      <= '0;
                        busyReg  <= 1'b1;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    idx <= idx + IDX_W'(1);
                    if (!weLat && idx != '0)
                        vrdataReg[capIdx*LANE_W +: LANE_W] <= bus.mem_rdata;
                    if (idx == LAST_IDX) begin
                        if (weLat) begin
                            state   <= DONE;
                            doneReg <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    vrdataReg[(LANES-1)*LANE_W +: LANE_W] <= bus.mem_rdata;
                    doneReg <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    doneReg <= 1'b0;
                    busyReg <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port mux: scalar passthrough except while lanes are issued or the last load drains.
    always_comb begin
        bus.mem_addr  = bus.s_addr;
        bus.mem_we    = bus.s_we;
        bus.mem_wdata = bus.s_wdata;
        bus.stall     = 1'b0;
        case (state)
            IDLE: bus.stall = bus.vstart;
            XFER: begin
                bus.mem_addr  = base + ADDR_W'({idx, 2'b00});
                bus.mem_we    = weLat;
                bus.mem_wdata = wdataLat[idx*LANE_W +: LANE_W];
                bus.stall     = 1'b1;
            end
            DRAIN: begin
                bus.mem_we = 1'b0;
                bus.stall  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy   = busyReg;
    assign bus.done   = doneReg;
    assign bus.vrdata = vrdataReg;
endmodule
